ic_edge_capture: RTL
====================

Name: ic_edge_capture

Overview:
- Input-capture event front end; sits directly upstream of the input-capture FIFO control block.
- Synchronises the external capture pin, detects edges per the selected capture mode (with prescaling), and emits one capture event per qualifying edge.
- Each event flips the `ins` level that the FIFO stage change-detects, and is also given as a one-cycle strobe.
- Also produces the capture-interrupt pulse after a programmable number of events.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `ic_pin`; legal values are 2 or more.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ic_pin  in  1  asynchronous external capture input.
- icon  in  1  module enable.
- icm  in  3  capture mode:
  - 000 off
  - 001 every edge
  - 010 every falling
  - 011 every rising
  - 100 every 4th rising
  - 101 every 16th rising
  - 110/111 treated as off
- ici  in  2  interrupt after ici+1 capture events.
- ins  out  1  toggles once per capture event; feeds the FIFO stage `ins`.
- cap_stb  out  1  one-cycle pulse per capture event.
- ic_if  out  1  one-cycle capture-interrupt pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - sync chain, prev-sample, prescale counter (4 bit), event counter (2 bit) and arm counter cleared.
  - ins=0, cap_stb=0, ic_if=0.
- Arming:
  - After reset release, edge detection is suppressed for SYNC_STAGES+1 cycles while the chain and prev-sample fill.
  - A pin held high through reset therefore causes no capture.
- Synchroniser and edge detection:
  - The synchroniser always runs, including when icon=0.
  - `s` = last sync stage; `p` = `s` delayed one cycle.
  - rise = s & ~p; fall = ~s & p.
- Event qualification, per mode:
  - 001: rise | fall
  - 010: fall
  - 011: rise
  - 100: rise with presc==3
  - 101: rise with presc==15
- Prescaler:
  - Increments on each rise in modes 100/101.
  - Wraps to 0 on the qualifying edge: 4-bit counter in mode 101, modulo 4 in mode 100.
  - Not used in other modes; held at 0.
- Latency:
  - A pin transition meeting setup before edge k gives cap_stb=1 in the cycle after edge k+SYNC_STAGES.
  - With SYNC_STAGES=2 that is the cycle after edge k+2.
  - ins toggles on the same edge cap_stb rises.
- Interrupt:
  - Event counter increments per capture event.
  - When counter==ici on an event: ic_if=1 coincident with cap_stb, and the counter clears.
  - With ici=0, ic_if accompanies every event.
- Mode change:
  - `icm` is registered internally. In any cycle where icm differs from its registered copy, no event is generated, and the prescale and event counters clear.
  - ins holds its value across a mode change.
- icon=0 or off mode:
  - No events; cap_stb=0 and ic_if=0.
  - Prescale and event counters held at 0; ins holds.
  - Re-enabling does not fire on a level present before enable. Edge detection uses `p`, which keeps tracking while disabled.
- Reset mid-operation: all state cleared at the next clk edge with rst_n=0; re-arming as above.
- Pulse spacing:
  - Pin pulses narrower than one clk period may be missed; no requirement applies to them.
  - Edges at least 1 cycle apart in `s` each produce their own event. Back-to-back events in consecutive cycles toggle ins each cycle.
- No backpressure: the downstream FIFO handles overflow.

Decomposition:
- Shared package `ic_pkg`:
  - ICM_OFF/ICM_EVERY/ICM_FALL/ICM_RISE/ICM_RISE4/ICM_RISE16 localparams.
  - icm width constant.
- One sub-module `ic_sync`:
  - parameterised SYNC_STAGES flop chain with synchronous active-low reset.
  - output `s` plus delayed `p`.

Test Plan:
- icon=1, icm=011, ici=0; pin 0→1 at cycle 10, 1→0 at cycle 20 → one cap_stb at cycle 13, ins 0→1, ic_if=1 at cycle 13; nothing at 20–25.
- icm=001, ici=2; 6 pin toggles spaced 5 cycles apart → 6 cap_stb pulses, ins ends at 0, ic_if on the 3rd and 6th events only.
- icm=100; 8 rising edges → cap_stb on rises 4 and 8 only. Switch to icm=101 after rise 2, then 16 more rises → one cap_stb on the 16th rise after the switch.
- Pin held 1 through reset, rst_n released at cycle 5 → no cap_stb for 30 cycles. A subsequent fall with icm=010 → cap_stb 3 cycles later.
- icon=0 while pin rises at cycle 10; icon=1 at cycle 20 → no event. Next fall with icm=001 → event.
- rst_n=0 for 1 cycle between the 2nd and 3rd rise in mode 100 → counters cleared, ins=0. The next 4 rises after re-arm → one cap_stb on the 4th.

Source files
------------

// File: rtl/ic_pkg.sv
// rtl/ic_pkg.sv - shared capture-mode encodings and widths for the input-capture front end
//
// Purpose : capture-mode codes, icm width and prescaler terminal counts used
//           by ic_edge_capture and its sub-blocks.
// Ports   : none (package).

package ic_pkg;

  localparam int ICM_W = 3;

  localparam logic [ICM_W-1:0] ICM_OFF    = 3'b000;
  localparam logic [ICM_W-1:0] ICM_EVERY  = 3'b001;
  localparam logic [ICM_W-1:0] ICM_FALL   = 3'b010;
  localparam logic [ICM_W-1:0] ICM_RISE   = 3'b011;
  localparam logic [ICM_W-1:0] ICM_RISE4  = 3'b100;
  localparam logic [ICM_W-1:0] ICM_RISE16 = 3'b101;

  localparam int PRESC_W = 4;

  // Counter value on which the qualifying rise lands (count starts at 0).
  localparam logic [PRESC_W-1:0] PRESC4_LAST  = 4'd3;
  localparam logic [PRESC_W-1:0] PRESC16_LAST = 4'd15;

endpackage

// File: rtl/ic_sync.sv
// rtl/ic_sync.sv - capture-pin synchroniser with one extra delayed sample
//
// Purpose : brings the asynchronous capture pin into the clk domain through
//           SYNC_STAGES flops and provides the last stage (s) plus a one-cycle
//           delayed copy (p) for edge detection.
// Ports   : i_clk   - system clock
//           i_rst_n - synchronous active-low reset
//           i_d     - asynchronous input
//           o_s     - synchronised level (last stage)
//           o_p     - o_s delayed by one cycle

module ic_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_s,
  output logic o_p
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_p;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_chain <= '0;
      r_p     <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      r_p     <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_s = r_chain[SYNC_STAGES-1];
  assign o_p = r_p;

endmodule

// File: rtl/ic_edge_capture.sv
// rtl/ic_edge_capture.sv - input-capture event front end (edge detect, prescale, interrupt)
//
// Purpose : synchronises the capture pin, qualifies edges per capture mode
//           (with /4 and /16 rising prescale), and emits one capture event
//           per qualifying edge: a level toggle on o_ins, a one-cycle o_cap_stb
//           and, every i_ici+1 events, a one-cycle o_ic_if.
// Ports   : i_clk     - system clock
//           i_rst_n   - synchronous active-low reset
//           i_ic_pin  - asynchronous capture pin
//           i_icon    - module enable
//           i_icm     - capture mode (see ic_pkg)
//           i_ici     - interrupt after i_ici+1 events
//           o_ins     - toggles once per capture event
//           o_cap_stb - one-cycle pulse per capture event
//           o_ic_if   - one-cycle capture-interrupt pulse

module ic_edge_capture
  import ic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ic_pin,
  input  logic             i_icon,
  input  logic [ICM_W-1:0] i_icm,
  input  logic [1:0]       i_ici,
  output logic             o_ins,
  output logic             o_cap_stb,
  output logic             o_ic_if
);

  // Arming lasts until the chain and the p sample hold post-reset data.
  localparam int ARM_LAST = SYNC_STAGES + 1;
  localparam int ARM_W    = $clog2(ARM_LAST + 1);

  logic               w_s;
  logic               w_p;
  logic [ARM_W-1:0]   r_arm;
  logic               w_armed;
  logic               w_rise;
  logic               w_fall;
  logic               w_mode_ok;
  logic               w_active;
  logic               w_qual;
  logic [PRESC_W-1:0] w_presc_nxt;

  logic [ICM_W-1:0]   r_icm;
  logic [PRESC_W-1:0] r_presc;
  logic [1:0]         r_evcnt;
  logic               r_ins;
  logic               r_cap_stb;
  logic               r_ic_if;

  ic_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_ic_pin),
    .o_s     (w_s),
    .o_p     (w_p)
  );

  assign w_armed = (r_arm == ARM_W'(ARM_LAST));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_arm <= '0;
    end else if (!w_armed) begin
      r_arm <= r_arm + 1'b1;
    end
  end

  // p keeps tracking while disabled, so a level already present at enable
  // time never looks like an edge.
  assign w_rise = w_armed & w_s & ~w_p;
  assign w_fall = w_armed & ~w_s & w_p;

  always_comb begin
    w_mode_ok = 1'b0;
    case (i_icm)
      ICM_EVERY, ICM_FALL, ICM_RISE, ICM_RISE4, ICM_RISE16: w_mode_ok = 1'b1;
      default:                                              w_mode_ok = 1'b0;
    endcase
  end

  // A cycle whose mode differs from the registered copy is dead: no event,
  // counters cleared.
  assign w_active = i_icon & w_mode_ok & (i_icm == r_icm);

  always_comb begin
    w_qual      = 1'b0;
    w_presc_nxt = '0;
    case (i_icm)
      ICM_EVERY: w_qual = w_rise | w_fall;
      ICM_FALL:  w_qual = w_fall;
      ICM_RISE:  w_qual = w_rise;
      ICM_RISE4: begin
        w_qual      = w_rise && (r_presc == PRESC4_LAST);
        w_presc_nxt = w_qual ? '0 : (w_rise ? r_presc + 1'b1 : r_presc);
      end
      ICM_RISE16: begin
        w_qual      = w_rise && (r_presc == PRESC16_LAST);
        w_presc_nxt = w_qual ? '0 : (w_rise ? r_presc + 1'b1 : r_presc);
      end
      default: begin
        w_qual      = 1'b0;
        w_presc_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_icm     <= ICM_OFF;
      r_presc   <= '0;
      r_evcnt   <= '0;
      r_ins     <= 1'b0;
      r_cap_stb <= 1'b0;
      r_ic_if   <= 1'b0;
    end else begin
      r_icm     <= i_icm;
      r_cap_stb <= 1'b0;
      r_ic_if   <= 1'b0;
      if (!w_active) begin
        r_presc <= '0;
        r_evcnt <= '0;
      end else begin
        r_presc <= w_presc_nxt;
        if (w_qual) begin
          r_cap_stb <= 1'b1;
          r_ins     <= ~r_ins;
          if (r_evcnt == i_ici) begin
            r_ic_if <= 1'b1;
            r_evcnt <= '0;
          end else begin
            r_evcnt <= r_evcnt + 1'b1;
          end
        end
      end
    end
  end

  assign o_ins     = r_ins;
  assign o_cap_stb = r_cap_stb;
  assign o_ic_if   = r_ic_if;

endmodule
